dht11_reader: RTL and testbench

DHT11_READER -- requirements
Module: dht11_reader

---
 rtl/dht11_reader.sv | 198 +++++++++++++++++++
 tb/tb_dht11_reader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dht11_reader.sv
// DHT11 single-wire sensor reader: start pulse, response handshake, 40-bit frame capture.
// Define DHT_CHECKSUM_EN to reject frames whose checksum byte does not match bytes 0-3.
module dht11_reader #(
  parameter int unsigned CLK_FREQ     = 100_000_000,
  parameter int unsigned START_LOW_MS = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  inout  wire        dht_io,
  output logic [7:0] humidity,
  output logic [7:0] current_temperature,
  output logic       valid,
  output logic       error,
  output logic       busy
);

  localparam int unsigned Div     = (CLK_FREQ / 1_000_000 > 0) ? CLK_FREQ / 1_000_000 : 1;
  localparam int unsigned DivW    = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned StartUs = START_LOW_MS * 1000;
  localparam int unsigned MaxUs   = (StartUs > 127) ? StartUs : 127;
  localparam int unsigned CntW    = $clog2(MaxUs + 2);

  localparam logic [DivW-1:0] DivLast   = DivW'(Div - 1);
  localparam logic [CntW-1:0] UsStart   = CntW'(StartUs);
  localparam logic [CntW-1:0] UsRelease = CntW'(30);
  localparam logic [CntW-1:0] Us100     = CntW'(100);
  localparam logic [CntW-1:0] Us80      = CntW'(80);
  localparam logic [CntW-1:0] Us40      = CntW'(40);

  typedef enum logic [3:0] {
    StIdle, StStartLow, StRelease, StRespWait, StRespLow,
    StRespHigh, StBitLow, StBitHigh, StCheck, StFail
  } state_e;

  state_e          state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [CntW-1:0] us_q, us_d;
  logic [5:0]      bit_cnt_q, bit_cnt_d;
  logic [39:0]     shift_q, shift_d;
  logic [7:0]      hum_q, hum_d, temp_q, temp_d;
  logic            valid_q, valid_d, error_q, error_d, busy_q, busy_d;
  logic            sync1_q, sync2_q, prev_q;

  logic            tick, line, rise, fall, state_chg, csum_ok, bit_val;
  logic [CntW-1:0] elapsed;

  assign line    = sync2_q;
  assign rise    = sync2_q & ~prev_q;
  assign fall    = ~sync2_q & prev_q;
  assign tick    = (div_q == DivLast);
  // Includes the current cycle's tick so a high time of N us measures exactly N.
  assign elapsed = us_q + CntW'(tick);
  assign bit_val = (elapsed > Us40);

`ifdef DHT_CHECKSUM_EN
  assign csum_ok = (shift_q[39:32] + shift_q[31:24] + shift_q[23:16] + shift_q[15:8])
                   == shift_q[7:0];
`else
  logic unused_bytes;
  assign unused_bytes = ^{shift_q[31:24], shift_q[15:0]};
  assign csum_ok      = 1'b1;
`endif

  assign dht_io = (state_q == StStartLow) ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (start) state_d = StStartLow;
      StStartLow: if (elapsed >= UsStart) state_d = StRelease;
      StRelease:  if (elapsed >= UsRelease) state_d = StRespWait;
      StRespWait: begin
        if (!line)                 state_d = StRespLow;
        else if (elapsed >= Us100) state_d = StFail;
      end
      StRespLow: begin
        if (rise)                  state_d = StRespHigh;
        else if (elapsed >= Us100) state_d = StFail;
      end
      StRespHigh: begin
        if (fall)                  state_d = StBitLow;
        else if (elapsed >= Us100) state_d = StFail;
      end
      StBitLow: begin
        if (rise)                 state_d = StBitHigh;
        else if (elapsed >= Us80) state_d = StFail;
      end
      StBitHigh: begin
        if (fall)                  state_d = (bit_cnt_q == 6'd39) ? StCheck : StBitLow;
        else if (elapsed >= Us100) state_d = StFail;
      end
      StCheck, StFail: state_d = StIdle;
      default:         state_d = StIdle;
    endcase
  end

  always_comb begin
    hum_d     = hum_q;
    temp_d    = temp_q;
    valid_d   = 1'b0;
    error_d   = error_q;
    busy_d    = busy_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          error_d   = 1'b0;
          busy_d    = 1'b1;
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      end
      StBitHigh: begin
        if (fall) begin
          shift_d   = {shift_q[38:0], bit_val};
          bit_cnt_d = bit_cnt_q + 6'd1;
        end
      end
      StCheck: begin
        busy_d = 1'b0;
        if (csum_ok) begin
          hum_d   = shift_q[39:32];
          temp_d  = shift_q[23:16];
          valid_d = 1'b1;
        end else begin
          error_d = 1'b1;
        end
      end
      StFail: begin
        busy_d  = 1'b0;
        error_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Microsecond timebase restarts on every state change so intervals are exact.
  assign state_chg = (state_d != state_q);

  always_comb begin
    div_d = div_q;
    us_d  = us_q;
    if (state_chg) begin
      div_d = '0;
      us_d  = '0;
    end else begin
      div_d = tick ? '0 : div_q + DivW'(1);
      if (tick) us_d = us_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q     <= '0;
      us_q      <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      hum_q     <= '0;
      temp_q    <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      busy_q    <= 1'b0;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
    end else begin
      div_q     <= div_d;
      us_q      <= us_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      hum_q     <= hum_d;
      temp_q    <= temp_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
      busy_q    <= busy_d;
      sync1_q   <= dht_io;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
    end
  end

  assign humidity            = hum_q;
  assign current_temperature = temp_q;
  assign valid               = valid_q;
  assign error               = error_q;
  assign busy                = busy_q;

endmodule

// File: tb/tb_dht11_reader.sv
// Randomised bench for dht11_reader: behavioural sensor, reference decoder and valid scoreboard.
`timescale 1ns/1ps
module tb_dht11_reader;

  localparam int unsigned CycPerUs = 2;
  localparam int unsigned StartUs  = 1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       sensor_low = 1'b0;
  wire        dht_line;
  logic [7:0] hum, temp;
  logic       valid, error, busy;

  pullup (dht_line);
  assign dht_line = sensor_low ? 1'b0 : 1'bz;

  dht11_reader #(
    .CLK_FREQ    (2_000_000),
    .START_LOW_MS(1)
  ) dut (
    .clk                (clk),
    .reset              (rst_n),
    .start              (start),
    .dht_io             (dht_line),
    .humidity           (hum),
    .current_temperature(temp),
    .valid              (valid),
    .error              (error),
    .busy               (busy)
  );

  always #250 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         valid_seen = 0;
  logic [15:0] exp_q[$];
  logic [7:0] last_hum = 8'h00;
  logic [7:0] last_temp = 8'h00;
  int         hi_us[40];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_us(input int n);
    repeat (n * CycPerUs) @(negedge clk);
  endtask

  // Scoreboard monitor: every valid pulse must match the oldest expected frame.
  always @(negedge clk) begin
    if (rst_n && valid === 1'b1) begin
      valid_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got a valid pulse, required none");
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("valid_humidity", hum, e[15:8]);
        chk("valid_temperature", temp, e[7:0]);
        chk("valid_error", error, 1'b0);
      end
    end
  end

  // Reference decoder: a bit is 1 when its high time exceeds 40 us.
  function automatic logic [39:0] decode_frame();
    logic [39:0] f;
    for (int i = 0; i < 40; i++) f[39-i] = (hi_us[i] > 40);
    return f;
  endfunction

  function automatic bit frame_ok(input logic [39:0] f);
`ifdef DHT_CHECKSUM_EN
    int sum;
    sum = f[39:32] + f[31:24] + f[23:16] + f[15:8];
    return (sum % 256) == int'(f[7:0]);
`else
    return f[0] | ~f[0];
`endif
  endfunction

  task automatic set_frame(input logic [39:0] f);
    for (int i = 0; i < 40; i++)
      hi_us[i] = f[39-i] ? int'($urandom_range(45, 60)) : int'($urandom_range(18, 30));
  endtask

  function automatic logic [39:0] rand_frame(input int bad);
    logic [7:0] b0, b1, b2, b3, b4;
    b0 = 8'($urandom_range(0, 99));
    b1 = 8'($urandom_range(0, 9));
    b2 = 8'($urandom_range(0, 50));
    b3 = 8'($urandom_range(0, 9));
    b4 = b0 + b1 + b2 + b3 + 8'(bad);
    return {b0, b1, b2, b3, b4};
  endfunction

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic reset_now();
    rst_n = 1'b0;
    #1;
    chk("reset_float", dht_line, 1'b1);
    chk("reset_humidity", hum, 8'h00);
    chk("reset_temperature", temp, 8'h00);
    chk("reset_valid", valid, 1'b0);
    chk("reset_error", error, 1'b0);
    chk("reset_busy", busy, 1'b0);
    last_hum  = 8'h00;
    last_temp = 8'h00;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic sensor_respond(input int abort_bit);
    int n;
    n = 0;
    while (dht_line !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    if (dht_line !== 1'b0) begin
      chk("host_start_low", dht_line, 1'b0);
      return;
    end
    n = 0;
    while (dht_line !== 1'b1 && n < 2 * CycPerUs * StartUs) begin @(negedge clk); n++; end
    chk("start_low_length", (n >= CycPerUs * StartUs - 4) && (n <= CycPerUs * StartUs + 4), 1);
    wait_us(35);
    sensor_low = 1'b1; wait_us(80);
    sensor_low = 1'b0; wait_us(80);
    for (int i = 0; i < 40; i++) begin
      sensor_low = 1'b1; wait_us(25);
      sensor_low = 1'b0;
      if (i == abort_bit) begin
        wait_us(10);
        reset_now();
        return;
      end
      wait_us(hi_us[i]);
    end
    sensor_low = 1'b1; wait_us(25);
    sensor_low = 1'b0;
  endtask

  task automatic run_read(input int abort_bit);
    logic [39:0] f;
    bit          ok;
    int          n;
    f  = decode_frame();
    ok = frame_ok(f);
    if (abort_bit < 0 && ok) begin
      exp_q.push_back({f[39:32], f[23:16]});
      last_hum  = f[39:32];
      last_temp = f[23:16];
    end
    pulse_start();
    chk("busy_on_start", busy, 1'b1);
    sensor_respond(abort_bit);
    if (abort_bit < 0) begin
      n = 0;
      while (busy === 1'b1 && n < 1000) begin @(negedge clk); n++; end
      chk("busy_cleared", busy, 1'b0);
      chk("read_error", error, !ok);
      chk("hold_humidity", hum, last_hum);
      chk("hold_temperature", temp, last_temp);
    end
  endtask

  initial begin
    #45_000_000;
    $display("FAIL watchdog: got no finish, required finish within budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n, v0;
    int          sweep[4];
    logic [39:0] f;
    sweep = '{26, 40, 41, 70};

    repeat (5) @(negedge clk);
    chk("por_humidity", hum, 8'h00);
    chk("por_temperature", temp, 8'h00);
    chk("por_valid", valid, 1'b0);
    chk("por_error", error, 1'b0);
    chk("por_busy", busy, 1'b0);
    chk("por_float", dht_line, 1'b1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    set_frame(40'h37_00_19_00_50);
    run_read(-1);
    chk("known_humidity", hum, 8'd55);
    chk("known_temperature", temp, 8'd25);

    // Sensor silent: the read must time out with outputs held.
    pulse_start();
    n = 0;
    while (dht_line !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    n = 0;
    while (dht_line !== 1'b1 && n < 2 * CycPerUs * StartUs + 100) begin @(negedge clk); n++; end
    wait_us(125);
    chk("silent_error_early", error, 1'b0);
    chk("silent_busy_early", busy, 1'b1);
    wait_us(10);
    chk("silent_error", error, 1'b1);
    chk("silent_busy", busy, 1'b0);
    chk("silent_humidity", hum, last_hum);
    chk("silent_temperature", temp, last_temp);

    set_frame(40'h37_00_19_00_51);
    run_read(-1);

    for (int i = 0; i < 40; i++) hi_us[i] = sweep[i % 4];
    run_read(-1);

    pulse_start();
    wait_us(100);
    chk("host_drives_low", dht_line, 1'b0);
    reset_now();
    repeat (3) @(negedge clk);

    set_frame(rand_frame(0));
    run_read(20);
    repeat (3) @(negedge clk);
    set_frame(rand_frame(0));
    run_read(-1);

    set_frame(rand_frame(0));
    v0 = valid_seen;
    fork
      run_read(-1);
      begin
        wait_us(200);  pulse_start();
        wait_us(1300); pulse_start();
        wait_us(600);  pulse_start();
        wait_us(600);  pulse_start();
      end
    join
    repeat (10) @(negedge clk);
    chk("single_valid", valid_seen - v0, 1);

    f = rand_frame(int'($urandom_range(0, 1)));
    set_frame(f);
    run_read(-1);

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
